// File: rtl/step_counter_unit.sv
// step_counter_unit: registered WIDTH-bit counter with step inc/dec/load, wrap or saturate,
// carry/borrow pulse, sticky overflow and terminal-count compare.
module step_counter_unit #(
  parameter int WIDTH = 32,
  parameter int STEP_WIDTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmdValid,
  input  logic [0:1]            cmd,
  input  logic                  satMode,
  input  logic [0:STEP_WIDTH-1] step,
  input  logic [0:WIDTH-1]      loadVal,
  input  logic [0:WIDTH-1]      limit,
  input  logic                  clrSticky,
  output logic [0:WIDTH-1]      cnt,
  output logic                  outC,
  output logic                  ovfSticky,
  output logic                  tc
);
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             c_q, c_d, ovf_q, ovf_d;
  logic [WIDTH:0]   step_x, sum, diff;
  logic             inc, dec, load;
  assign step_x = {{(WIDTH+1-STEP_WIDTH){1'b0}}, step};
  assign sum    = {1'b0, cnt_q} + step_x;
  assign diff   = {1'b0, cnt_q} - step_x;
  assign inc    = cmdValid && cmd == 2'b01;
  assign dec    = cmdValid && cmd == 2'b10;
  assign load   = cmdValid && cmd == 2'b11;
  // Bit WIDTH of sum/diff is the carry/borrow; saturation clamps instead of wrapping.
  always_comb begin
    c_d   = inc ? sum[WIDTH] : dec ? diff[WIDTH] : 1'b0;
    cnt_d = inc  ? ((satMode && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0]) :
            dec  ? ((satMode && diff[WIDTH]) ? {WIDTH{1'b0}} : diff[WIDTH-1:0]) :
            load ? loadVal : cnt_q;
    ovf_d = (ovf_q & ~clrSticky) | c_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RESET_VAL;
      c_q   <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt       = cnt_q;
  assign outC      = c_q;
  assign ovfSticky = ovf_q;
  assign tc        = cnt_q == limit;
endmodule

// File: tb/tb_step_counter_unit.sv
// tb_step_counter_unit: randomized scoreboard bench for step_counter_unit against an
// integer-arithmetic reference model.
module tb_step_counter_unit;
  localparam longint MAXV = 64'h0_FFFF_FFFF;
  logic        clk = 0, rst = 0, cmdValid = 0, satMode = 0, clrSticky = 0;
  logic [1:0]  cmd = 0;
  logic [3:0]  step = 0;
  logic [31:0] loadVal = 0, limit = 0, cnt;
  logic        outC, ovfSticky, tc;
  typedef struct { longint c; bit oc; bit ov; logic [31:0] lim; } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  longint mc = 0;
  bit mov = 0;

  step_counter_unit dut (
    .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmd(cmd), .satMode(satMode),
    .step(step), .loadVal(loadVal), .limit(limit), .clrSticky(clrSticky),
    .cnt(cnt), .outC(outC), .ovfSticky(ovfSticky), .tc(tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a new result after every rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("cnt", cnt, e.c);
      check("outC", outC, e.oc);
      check("ovfSticky", ovfSticky, e.ov);
      check("tc", tc, (e.c == e.lim));
    end
  end

  task automatic issue(input bit v, input bit [1:0] c, input bit s, input int stp,
                       input logic [31:0] lv, input logic [31:0] lim, input bit clr);
    longint t;
    bit carry;
    @(posedge clk); #2;
    cmdValid = v; cmd = c; satMode = s; step = 4'(stp); loadVal = lv; limit = lim; clrSticky = clr;
    carry = 0;
    if (v && c == 2'b01) begin
      t = mc + stp;
      carry = t > MAXV;
      mc = !carry ? t : s ? MAXV : t - (MAXV + 1);
    end else if (v && c == 2'b10) begin
      t = mc - stp;
      carry = t < 0;
      mc = !carry ? t : s ? 0 : t + (MAXV + 1);
    end else if (v && c == 2'b11) mc = lv;
    mov = (mov && !clr) || carry;
    q.push_back('{mc, carry, mov, lim});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] lv, lim;
    int r;
    repeat (3) @(posedge clk);
    #2;
    check("reset cnt", cnt, 0);
    check("reset outC", outC, 0);
    check("reset ovf", ovfSticky, 0);
    check("reset tc", tc, 1);
    rst = 1;
    repeat (3) issue(0, 2'b01, 0, 1, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 32'hFFFF_FFFE, 0, 0);
    issue(1, 2'b01, 0, 1, 0, 0, 0);
    issue(1, 2'b01, 0, 1, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 32'hFFFF_FFF0, 0, 0);
    issue(1, 2'b01, 1, 15, 0, 0, 0);
    issue(1, 2'b01, 1, 15, 0, 0, 0);
    issue(1, 2'b01, 1, 15, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 5, 0, 0);
    issue(1, 2'b10, 0, 8, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 5, 0, 0);
    issue(1, 2'b10, 1, 8, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 32'hFFFF_FFFF, 0, 0);
    issue(1, 2'b01, 0, 3, 0, 0, 1);
    issue(0, 2'b00, 0, 0, 0, 0, 1);
    issue(1, 2'b01, 0, 0, 0, 0, 0);
    issue(1, 2'b10, 1, 0, 0, 0, 0);
    issue(1, 2'b11, 0, 0, 10, 12, 0);
    issue(1, 2'b01, 0, 1, 0, 12, 0);
    issue(1, 2'b01, 0, 1, 0, 12, 0);
    // Asynchronous reset between edges with an increment in flight.
    @(posedge clk); #2;
    cmdValid = 1; cmd = 2'b01; step = 4'd1; limit = 12;
    #2 rst = 0;
    #1;
    check("async rst cnt", cnt, 0);
    check("async rst outC", outC, 0);
    check("async rst ovf", ovfSticky, 0);
    check("async rst tc", tc, 0);
    @(posedge clk); #2;
    check("rst held cnt", cnt, 0);
    cmdValid = 0; rst = 1;
    mc = 0; mov = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 3);
      lv = r == 0 ? 32'hFFFF_FFFF - $urandom_range(0, 20) : r == 1 ? $urandom_range(0, 20) : $urandom;
      lim = $urandom_range(0, 1) ? 32'(mc + $urandom_range(0, 2)) : $urandom;
      issue($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 15), lv, lim, $urandom_range(0, 7) == 0);
    end
    @(posedge clk); #2;
    cmdValid = 0;
    repeat (2) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
